hazard_scoreboard_unit: RTL

Parametrised hazard and forwarding controller for the ARM-style 5-stage pipeline. It sits beside ID and drives the per-operand forwarding mux selects, the PC and IF/ID load enables, and NOP insertion into ID/EXE. It generalises the single-cycle load-use check in three ways:
- any number of source operands;
- a configurable load latency, tracked by a per-register countdown scoreboard;
- a multi-cycle branch-flush state machine.
It also keeps a saturating stall-cycle counter.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/fwd_select.sv | 35 +++
 rtl/hazard_scoreboard_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard/forwarding controller.
package hazard_pkg;

  // Forwarding mux select encodings.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // Width of each per-register load countdown.
  localparam int CNT_W = 3;

  // Branch flush state machine states.
  typedef enum logic {
    IDLE,
    FLUSH
  } flush_state_t;

endpackage

// File: rtl/fwd_select.sv
// Priority forwarding selector for a single ID source operand.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int REG_W    = 4
) (
  input  logic [REG_W-1:0] i_src,
  input  logic             i_used,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_rf_en,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_mem_rf_en,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic             i_wb_rf_en,
  output logic [1:0]       o_sel
);

  localparam logic [REG_W-1:0] PC_IDX = REG_W'(NUM_REGS - 1);

  // Youngest matching producer wins; unused operands and the PC always read the register file.
  always_comb begin
    o_sel = FWD_RF;
    if (i_used && (i_src != PC_IDX)) begin
      if (i_ex_rf_en && (i_ex_rd == i_src)) begin
        o_sel = FWD_EX;
      end else if (i_mem_rf_en && (i_mem_rd == i_src)) begin
        o_sel = FWD_MEM;
      end else if (i_wb_rf_en && (i_wb_rd == i_src)) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard and forwarding controller: per-operand forwarding selects, load-use
// stalls from a per-register countdown scoreboard, and a multi-cycle branch flush.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_REGS     = 16,
  parameter int REG_W        = 4,
  parameter int NUM_SRC      = 3,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int STAT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_id_valid,
  input  logic [NUM_SRC*REG_W-1:0] i_id_src,
  input  logic [NUM_SRC-1:0]       i_id_src_used,
  input  logic [REG_W-1:0]         i_id_rd,
  input  logic                     i_id_rf_en,
  input  logic                     i_id_load,
  input  logic [REG_W-1:0]         i_ex_rd,
  input  logic [REG_W-1:0]         i_mem_rd,
  input  logic [REG_W-1:0]         i_wb_rd,
  input  logic                     i_ex_rf_en,
  input  logic                     i_mem_rf_en,
  input  logic                     i_wb_rf_en,
  input  logic                     i_branch_taken,
  output logic [2*NUM_SRC-1:0]     o_fwd_sel,
  output logic                     o_pc_le,
  output logic                     o_ifid_le,
  output logic                     o_flush_ifid,
  output logic                     o_nop_insert,
  output logic [STAT_W-1:0]        o_stall_count
);

  localparam logic [CNT_W-1:0] LOAD_LAT_C = CNT_W'(LOAD_LAT);
  localparam logic [1:0]       FC_RELOAD  = 2'(FLUSH_CYCLES - 1);

  logic [CNT_W-1:0]     r_cnt [NUM_REGS];
  flush_state_t         r_state;
  flush_state_t         w_state_next;
  logic [1:0]           r_fc;
  logic [1:0]           w_fc_next;
  logic [STAT_W-1:0]    r_stall_count;
  logic                 w_stall;
  logic                 w_flush;
  logic                 w_issue;
  logic [2*NUM_SRC-1:0] w_fwd_sel;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    fwd_select #(
      .NUM_REGS(NUM_REGS),
      .REG_W   (REG_W)
    ) u_fwd_select (
      .i_src      (i_id_src[g*REG_W +: REG_W]),
      .i_used     (i_id_src_used[g]),
      .i_ex_rd    (i_ex_rd),
      .i_ex_rf_en (i_ex_rf_en),
      .i_mem_rd   (i_mem_rd),
      .i_mem_rf_en(i_mem_rf_en),
      .i_wb_rd    (i_wb_rd),
      .i_wb_rf_en (i_wb_rf_en),
      .o_sel      (w_fwd_sel[2*g +: 2])
    );
  end

  // Load-use hazard: any read operand whose register still has a pending load.
  always_comb begin
    w_stall = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i_id_src_used[i] && (r_cnt[i_id_src[i*REG_W +: REG_W]] != '0)) begin
        w_stall = 1'b1;
      end
    end
    w_stall = w_stall & i_id_valid;
  end

  assign w_issue = i_id_valid & ~w_stall & ~w_flush;

  // Flush FSM next state: a taken branch flushes immediately and, for longer flushes, arms the countdown.
  always_comb begin
    w_state_next = r_state;
    w_fc_next    = r_fc;
    w_flush      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_branch_taken) begin
          w_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_state_next = FLUSH;
            w_fc_next    = FC_RELOAD;
          end
        end
      end
      FLUSH: begin
        w_flush = 1'b1;
        if (i_branch_taken) begin
          w_fc_next = FC_RELOAD;
        end else if (r_fc == 2'd1) begin
          w_state_next = IDLE;
          w_fc_next    = 2'd0;
        end else begin
          w_fc_next = r_fc - 2'd1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_fc_next    = 2'd0;
      end
    endcase
  end

  // Flush FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_fc    <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_fc    <= w_fc_next;
    end
  end

  // Scoreboard: an issuing writer reloads its register's count, all other pending counts drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_issue && i_id_rf_en && (i_id_rd == REG_W'(r))) begin
          r_cnt[r] <= i_id_load ? LOAD_LAT_C : '0;
        end else if (r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - CNT_W'(1);
        end
      end
    end
  end

  // Saturating count of genuine load-use stall cycles; flush cycles are not stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_stall && !w_flush && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + STAT_W'(1);
    end
  end

  // Pipeline control: flush beats stall so the branch target is fetched; reset forces idle values.
  always_comb begin
    o_fwd_sel    = '0;
    o_pc_le      = 1'b1;
    o_ifid_le    = 1'b1;
    o_flush_ifid = 1'b0;
    o_nop_insert = 1'b0;
    if (!reset) begin
      o_fwd_sel = w_fwd_sel;
      if (w_flush) begin
        o_flush_ifid = 1'b1;
        o_nop_insert = 1'b1;
      end else if (w_stall) begin
        o_pc_le      = 1'b0;
        o_ifid_le    = 1'b0;
        o_nop_insert = 1'b1;
      end
    end
  end

  assign o_stall_count = r_stall_count;

endmodule
